// File: rtl/cpu_program_loader_pkg.sv
// Shared types for the CPU program loader: FSM state encoding and error codes.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PRESENT,
    ADVANCE,
    WAIT_DONE,
    FINISH,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_EARLY_DONE = 2'd1;
  localparam logic [1:0] ERR_EXTRA_REQ  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

endpackage

// File: rtl/cpu_program_loader_if.sv
// Loader <-> CPU program-load handshake: the loader drives the programming pin
// and data bus, the CPU answers with ready and done_load.
interface cpu_program_loader_if;
  logic       prog_mode;
  logic [7:0] prog_data;
  logic       cpu_ready;
  logic       cpu_done_load;

  modport master (output prog_mode, output prog_data, input cpu_ready, input cpu_done_load);
  modport slave  (input prog_mode, input prog_data, output cpu_ready, output cpu_done_load);
endinterface

// File: rtl/loader_sync.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall
// pulses derived from the synchronized value.
module loader_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], async_in};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign sync = chain_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/cpu_program_loader.sv
// Host-side program loader: streams a RAM_BYTES image into the CPU over the
// ready/done_load handshake. Optional watchdog built when LOADER_TIMEOUT_EN is defined.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int RAM_BYTES      = 16,
  parameter int ADDR_W         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                img_wr_en,
  input  logic [ADDR_W-1:0]   img_wr_addr,
  input  logic [7:0]          img_wr_data,
  input  logic                start,
  cpu_program_loader_if.master cpu,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     bytes_sent
);

  state_t            state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              prog_mode_reg;
  logic [7:0]        prog_data_reg;
  logic [7:0]        image [RAM_BYTES];

  logic rdy_s, rdy_rise, rdy_fall;
  logic dl_s, dl_rise, dl_fall;
  logic tmo_hit;

  loader_sync #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk(clk), .rst_n(rst_n), .async_in(cpu.cpu_ready),
    .sync(rdy_s), .rise(rdy_rise), .fall(rdy_fall)
  );

  loader_sync #(.STAGES(SYNC_STAGES)) u_sync_dl (
    .clk(clk), .rst_n(rst_n), .async_in(cpu.cpu_done_load),
    .sync(dl_s), .rise(dl_rise), .fall(dl_fall)
  );

  logic unused_dl_edges;
  assign unused_dl_edges = &{1'b0, dl_rise, dl_fall};

  logic              wr_ok;
  logic [ADDR_W-1:0] idx_inc;
  logic [7:0]        rd_first, rd_idx;

  assign wr_ok   = img_wr_en && (state_reg == IDLE || state_reg == ERROR);
  assign idx_inc = idx_reg + 1'b1;
  // Forward a same-cycle write so a load started alongside it sees the new byte.
  assign rd_first = (wr_ok && img_wr_addr == '0) ? img_wr_data : image[0];
  assign rd_idx   = (wr_ok && img_wr_addr == idx_reg) ? img_wr_data : image[idx_reg];

  always_ff @(posedge clk) begin
    if (wr_ok) image[img_wr_addr] <= img_wr_data;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;
  state_t           state_prev_reg;
  logic             counting;
  logic [CNT_W-1:0] cnt_eff;

  // The count restarts on the first cycle of any new state.
  assign counting = state_reg inside {ARM, PRESENT, WAIT_DONE};
  assign cnt_eff  = (state_reg != state_prev_reg) ? '0 : tmo_cnt_reg;
  assign tmo_hit  = counting && (cnt_eff == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg    <= '0;
      state_prev_reg <= IDLE;
    end else begin
      state_prev_reg <= state_reg;
      tmo_cnt_reg    <= counting ? cnt_eff + 1'b1 : '0;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  task automatic enter_error(input logic [1:0] code);
    state_reg     <= ERROR;
    prog_mode_reg <= 1'b0;
    busy          <= 1'b0;
    error         <= 1'b1;
    err_code      <= code;
  endtask

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      prog_mode_reg <= 1'b0;
      prog_data_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      bytes_sent    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, ERROR: begin
          if (start) begin
            state_reg     <= ARM;
            idx_reg       <= '0;
            bytes_sent    <= '0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            prog_data_reg <= rd_first;
            prog_mode_reg <= 1'b1;
            busy          <= 1'b1;
          end else if (state_reg == IDLE) begin
            prog_data_reg <= rd_idx;
          end
        end
        ARM: begin
          if (dl_s)         enter_error(ERR_EARLY_DONE);
          else if (rdy_s)   state_reg <= PRESENT;
          else if (tmo_hit) enter_error(ERR_TIMEOUT);
        end
        PRESENT: begin
          if (rdy_fall) begin
            if (bytes_sent < (ADDR_W+1)'(RAM_BYTES)) bytes_sent <= bytes_sent + 1'b1;
            state_reg <= (idx_reg == ADDR_W'(RAM_BYTES - 1)) ? WAIT_DONE : ADVANCE;
          end else if (dl_s) begin
            enter_error(ERR_EARLY_DONE);
          end else if (tmo_hit) begin
            enter_error(ERR_TIMEOUT);
          end
        end
        ADVANCE: begin
          idx_reg       <= idx_inc;
          prog_data_reg <= image[idx_inc];
          state_reg     <= ARM;
        end
        WAIT_DONE: begin
          if (dl_s) begin
            state_reg     <= FINISH;
            prog_mode_reg <= 1'b0;
            done          <= 1'b1;
          end else if (rdy_rise) begin
            enter_error(ERR_EXTRA_REQ);
          end else if (tmo_hit) begin
            enter_error(ERR_TIMEOUT);
          end
        end
        FINISH: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu.prog_mode = prog_mode_reg;
  assign cpu.prog_data = prog_data_reg;

endmodule
